icache_refill_axi: RTL
======================

Name: icache_refill_axi

Overview:
- Instruction-cache refill engine; sits directly upstream of the IFU port of the read arbiter.
- On an I-cache miss it fetches one full cache line as LINE_BEATS sequential single-beat AXI reads and assembles the beats in a line buffer.
- It then hands the complete line to the I-cache in a single-cycle pulse.
- It issues single-beat transactions (arlen=0) so each read is one arbitration grant, which lets the arbiter insert MEM reads between beats.

Parameters:
- LINE_BEATS, 4, number of 64-bit words per line; power of 2, range 2..16.
- AXI_ID, 4'h0, value driven on arid.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- miss_req  input  1  I-cache requests a refill.
- miss_addr  input  32  fetch address that missed.
- miss_ready  output  1  engine can accept a miss.
- flush  input  1  pipeline flush / fence.i; discard the refill in progress.
- line_valid  output  1  one-cycle pulse: line_data is complete.
- line_err  output  1  qualified by line_valid; some beat returned rresp!=0.
- line_addr  output  32  line-aligned base address of line_data.
- line_data  output  64*LINE_BEATS  word k in bits [64k+63:64k].
- arvalid / arready  output / input  1  AR handshake.
- araddr  output  32  beat address.
- arid  output  4  AXI_ID.
- arlen  output  8  constant 0.
- arsize  output  3  constant 3'b011.
- arburst  output  2  constant 2'b01.
- rvalid / rready  input / output  1  R handshake.
- rresp  input  2  response code.
- rdata  input  64  read data.
- rlast  input  1  ignored (always 1 for single beats).
- rid  input  4  ignored.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State=IDLE; beat counter=0; discard=0; err=0; base=0; buffer=0.
  - Outputs: arvalid=0, rready=0, line_valid=0, line_err=0, miss_ready=1.
- Line geometry:
  - OFS = log2(LINE_BEATS*8).
  - base = {miss_addr[31:OFS], OFS'b0}.
  - araddr = base + (beat<<3), where beat is a log2(LINE_BEATS)-bit counter that wraps modulo LINE_BEATS.
- IDLE:
  - miss_ready=1.
  - miss_req & miss_ready: latch base; beat=start; err=0; discard=0; next state AR.
  - A flush in the same cycle as acceptance wins: the miss is not accepted and the state stays IDLE.
- AR:
  - arvalid=1; araddr held stable.
  - arvalid stays high until arready, even if flush arrives.
  - arvalid&arready -> R.
- R:
  - rready=1.
  - On rvalid:
    - Write rdata into buffer word beat.
    - If rresp!=0, set err.
  - Then:
    - discard set (or flush this cycle) -> IDLE.
    - Else err set or last beat -> DONE.
    - Else beat++ and -> AR.
  - At least 1 idle cycle on arvalid between consecutive beats (AR after R).
- DONE:
  - line_valid = ~flush for exactly one cycle; line_err=err; line_addr=base.
  - Next state IDLE.
  - On error, the line_data words not yet fetched hold stale contents; the cache must not install a line with line_err=1.
- Flush in AR or R: set discard. The outstanding beat completes normally (AXI transactions are never abandoned), then the engine returns to IDLE without line_valid.
- Flush in IDLE with no miss: no effect.
- miss_ready=0 in every state except IDLE; miss_req is ignored there.
- line_data and line_addr are registered and stable from DONE until the next accepted miss.
- Latency (arready and rvalid immediate): miss accept -> line_valid = 2*LINE_BEATS+1 cycles.

Optional Feature:
- Macro: ICACHE_REFILL_CWF_EN (critical word first).
- Defined:
  - Starting beat = miss_addr[OFS-1:3], wrapping through all LINE_BEATS words.
  - Adds output crit_valid (1-bit pulse) and crit_data (64): pulsed in the same cycle as the first beat's R handshake, carrying rdata, when rresp==0 and not discarding.
  - The last beat is start-1 mod LINE_BEATS.
- Undefined:
  - Starting beat=0; order is 0..LINE_BEATS-1.
  - crit_valid and crit_data ports do not exist.

Test Plan:
- Basic refill: miss_addr=0x8000_0014, arready=1, rvalid one cycle after AR, rdata=0x1111*k, rresp=0 -> araddr 0x8000_0000, 08, 10, 18; line_valid at cycle 9 after accept; line_addr=0x8000_0000; word2=0x2222; line_err=0.
- Backpressure: arready low 3 cycles, rvalid delayed 5 cycles per beat -> araddr and arvalid stable until handshake; data correct; exactly one line_valid pulse.
- Error: beat1 rresp=2'b10 -> no AR for beats 2 and 3; line_valid=1 with line_err=1 one cycle after the R handshake.
- Flush mid-refill: flush asserted while in AR of beat 2 with arready=0 -> arvalid held until arready; the R beat is accepted; return to IDLE; line_valid never asserts; miss_ready=1.
- Reset mid-operation: rst_n low during R -> arvalid=0, rready=0, line_valid=0, miss_ready=1 immediately (asynchronous); a new miss after reset refills correctly.
- CWF (macro defined): miss_addr=0x8000_0018 -> araddr order 18, 00, 08, 10; crit_valid with crit_data equal to the first rdata on the first R handshake.

Source files
------------

// File: rtl/icache_refill_axi.sv
// icache_refill_axi: fetches one I-cache line as single-beat AXI reads and hands it over in a one-cycle pulse (ICACHE_REFILL_CWF_EN: critical word first)
module icache_refill_axi #(
  parameter int unsigned LINE_BEATS = 4,
  parameter logic [3:0]  AXI_ID     = 4'h0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    miss_req_i,
  input  logic [31:0]             miss_addr_i,
  output logic                    miss_ready_o,
  input  logic                    flush_i,
  output logic                    line_valid_o,
  output logic                    line_err_o,
  output logic [31:0]             line_addr_o,
  output logic [64*LINE_BEATS-1:0] line_data_o,
`ifdef ICACHE_REFILL_CWF_EN
  output logic                    crit_valid_o,
  output logic [63:0]             crit_data_o,
`endif
  output logic                    arvalid_o,
  input  logic                    arready_i,
  output logic [31:0]             araddr_o,
  output logic [3:0]              arid_o,
  output logic [7:0]              arlen_o,
  output logic [2:0]              arsize_o,
  output logic [1:0]              arburst_o,
  input  logic                    rvalid_i,
  output logic                    rready_o,
  input  logic [1:0]              rresp_i,
  input  logic [63:0]             rdata_i,
  input  logic                    rlast_i,
  input  logic [3:0]              rid_i
);
  localparam int unsigned OFS = $clog2(LINE_BEATS * 8);
  localparam int unsigned BW  = $clog2(LINE_BEATS);
  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_e;
  state_e                       state_q, state_d;
  logic [BW-1:0]                beat_q, start_q, start_d;
  logic                         discard_q, err_q;
  logic [31:0]                  base_q;
  logic [LINE_BEATS-1:0][63:0]  buf_q;
  logic                         accept, last, unused;
  // a flush in the acceptance cycle suppresses the miss
  assign accept = miss_req_i && state_q == IDLE && !flush_i;
  // beats run start, start+1, ... wrapping; the last one is start-1
  assign last = (beat_q + BW'(1)) == start_q;
  assign araddr_o = base_q | (32'(beat_q) << 3);
  assign arid_o = AXI_ID;
  assign arlen_o = 8'd0;
  assign arsize_o = 3'b011;
  assign arburst_o = 2'b01;
  assign line_addr_o = base_q;
  assign line_data_o = buf_q;
  assign unused = ^{rlast_i, rid_i, miss_addr_i[OFS-1:0]};
`ifdef ICACHE_REFILL_CWF_EN
  assign start_d = miss_addr_i[OFS-1:3];
  assign crit_valid_o = state_q == R && rvalid_i && rresp_i == 2'b00 && !discard_q && beat_q == start_q;
  assign crit_data_o = rdata_i;
`else
  assign start_d = '0;
`endif
  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state: an issued AR is always followed through its R beat, discard only decides where we land
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? AR : IDLE;
      AR:      state_d = arready_i ? R : AR;
      R:       state_d = !rvalid_i ? R : (discard_q || flush_i) ? IDLE :
                         (err_q || rresp_i != 2'b00 || last) ? DONE : AR;
      default: state_d = IDLE;
    endcase
  end
  // outputs decoded from state
  always_comb begin
    miss_ready_o = state_q == IDLE;
    arvalid_o = state_q == AR;
    rready_o = state_q == R;
    line_valid_o = state_q == DONE && !flush_i;
    line_err_o = state_q == DONE && err_q;
  end
  // line buffer, beat counter and sticky error/discard flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q <= '0;
      beat_q <= '0;
      start_q <= '0;
      err_q <= 1'b0;
      discard_q <= 1'b0;
      buf_q <= '0;
    end else if (accept) begin
      base_q <= miss_addr_i & ~32'(LINE_BEATS * 8 - 1);
      beat_q <= start_d;
      start_q <= start_d;
      err_q <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      if (flush_i && (state_q == AR || state_q == R)) discard_q <= 1'b1;
      if (state_q == R && rvalid_i) begin
        buf_q[beat_q] <= rdata_i;
        err_q <= err_q || rresp_i != 2'b00;
        beat_q <= beat_q + BW'(1);
      end
    end
  end
endmodule
